// File: rtl/addr_sequencer_if.sv
// Handshake bundle between an address sequencer and its controller/consumer.
// The master drives run requests and beat acceptance; the slave returns the address stream.
interface addr_sequencer_if #(
   parameter int ADDR_W = 3,
   parameter int LEN_W  = 4
);
   logic              start;
   logic [ADDR_W-1:0] base_i;
   logic [LEN_W-1:0]  len_i;
   logic [ADDR_W-1:0] stride_i;
   logic              adv_i;
   logic              abort_i;
   logic [ADDR_W-1:0] add_o;
   logic              valid_o;
   logic              busy_o;
   logic              done_o;
   logic              err_o;

   modport master (
      output start, base_i, len_i, stride_i, adv_i, abort_i,
      input  add_o, valid_o, busy_o, done_o, err_o
   );

   modport slave (
      input  start, base_i, len_i, stride_i, adv_i, abort_i,
      output add_o, valid_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/addr_sequencer.sv
// Programmable address sequencer: issues base, base+stride, ... for len beats,
// advancing on each consumer-accepted beat, in one-shot or continuous mode.
module addr_sequencer #(
   parameter int ADDR_W     = 3,
   parameter int LEN_W      = 4,
   parameter int CONTINUOUS = 0
) (
   input  logic             CLK,
   input  logic             RST,
   addr_sequencer_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [ADDR_W-1:0] add_q, add_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   // NOTE: every register, run parameters included, is reset so nothing is undefined after RST.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         base_q   <= '0;
         stride_q <= '0;
         len_q    <= '0;
         rem_q    <= '0;
         add_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state_q  <= state_d;
         base_q   <= base_d;
         stride_q <= stride_d;
         len_q    <= len_d;
         rem_q    <= rem_d;
         add_q    <= add_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
      state_d  = state_q;
      base_d   = base_q;
      stride_d = stride_q;
      len_d    = len_q;
      rem_d    = rem_q;
      add_d    = add_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Abort blocks both acceptance and the zero-length error.
            if (bus.start && !bus.abort_i) begin
               if (bus.len_i == '0) begin
                  err_d = 1'b1;
               end else begin
                  base_d   = bus.base_i;
                  stride_d = bus.stride_i;
                  len_d    = bus.len_i;
                  add_d    = bus.base_i;
                  rem_d    = bus.len_i - 1'b1;
                  state_d  = RUN;
               end
            end
         end
         RUN: begin
            if (bus.abort_i) begin
               state_d = IDLE;
            end else if (bus.adv_i) begin
               if (rem_q != '0) begin
                  add_d = add_q + stride_q;
                  rem_d = rem_q - 1'b1;
               end else begin
                  done_d = 1'b1;
                  if (CONTINUOUS != 0) begin
                     add_d = base_q;
                     rem_d = len_q - 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.add_o   = add_q;
   assign bus.valid_o = (state_q == RUN);
   assign bus.busy_o  = (state_q == RUN);
   assign bus.done_o  = done_q;
   assign bus.err_o   = err_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// Bench for addr_sequencer: table-driven one-shot runs through an address scoreboard,
// plus hand-written gap, abort, error, back-to-back, continuous and async-reset sequences.
module tb_addr_sequencer;
   localparam int AW = 3;
   localparam int LW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   addr_sequencer_if #(.ADDR_W(AW), .LEN_W(LW)) bus0 ();
   addr_sequencer_if #(.ADDR_W(AW), .LEN_W(LW)) bus1 ();

   addr_sequencer #(.ADDR_W(AW), .LEN_W(LW), .CONTINUOUS(0)) dut0 (
      .CLK (clk),
      .RST (rst),
      .bus (bus0.slave)
   );

   addr_sequencer #(.ADDR_W(AW), .LEN_W(LW), .CONTINUOUS(1)) dut1 (
      .CLK (clk),
      .RST (rst),
      .bus (bus1.slave)
   );

   typedef struct packed {
      logic [AW-1:0]       base;
      logic [LW-1:0]       len;
      logic [AW-1:0]       stride;
      logic [3:0][AW-1:0]  exp;
   } vec_t;

   int            tests_run    = 0;
   int            tests_failed = 0;
   logic [AW-1:0] exp_q [$];
   vec_t          vecs [5];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input int b, input int l, input int s,
                               input int e0, input int e1, input int e2, input int e3);
      vec_t v;
      v.base   = AW'(b);
      v.len    = LW'(l);
      v.stride = AW'(s);
      v.exp[0] = AW'(e0);
      v.exp[1] = AW'(e1);
      v.exp[2] = AW'(e2);
      v.exp[3] = AW'(e3);
      return v;
   endfunction

   task automatic clear_inputs();
      bus0.start = 1'b0; bus0.base_i = '0; bus0.len_i = '0; bus0.stride_i = '0;
      bus0.adv_i = 1'b0; bus0.abort_i = 1'b0;
      bus1.start = 1'b0; bus1.base_i = '0; bus1.len_i = '0; bus1.stride_i = '0;
      bus1.adv_i = 1'b0; bus1.abort_i = 1'b0;
   endtask

   task automatic start0(input int b, input int l, input int s);
      bus0.start    = 1'b1;
      bus0.base_i   = AW'(b);
      bus0.len_i    = LW'(l);
      bus0.stride_i = AW'(s);
   endtask

   // One-shot run on dut0 with adv_i held high; expected addresses are already queued.
   task automatic run_sb(input string tag, input int b, input int l, input int s);
      logic [AW-1:0] last;
      int            done_cnt;
      done_cnt = 0;
      last     = exp_q[$];
      @(negedge clk);
      start0(b, l, s);
      bus0.adv_i = 1'b1;
      for (int c = 0; c < l + 3; c++) begin
         @(negedge clk);
         bus0.start = 1'b0;
         if (bus0.done_o) done_cnt++;
         if (bus0.valid_o) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL %s_extra_beat: got add_o=%0d, expected no beat", tag, bus0.add_o);
            end else begin
               check({tag, "_addr"}, bus0.add_o, exp_q.pop_front());
            end
         end
      end
      check({tag, "_missing_beats"}, exp_q.size(), 0);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_valid_after"}, bus0.valid_o, 0);
      check({tag, "_add_holds"}, bus0.add_o, last);
      exp_q.delete();
      bus0.adv_i = 1'b0;
   endtask

   initial begin
      int adv_pat [5];
      int gap_add [5];
      int cexp    [6];
      int cdone   [6];
      adv_pat = '{1, 0, 0, 1, 1};
      gap_add = '{0, 1, 1, 1, 2};
      cexp    = '{2, 5, 2, 5, 2, 5};
      cdone   = '{0, 0, 1, 0, 1, 0};

      vecs[0] = mk(0, 4, 1, 0, 1, 2, 3);
      vecs[1] = mk(6, 3, 1, 6, 7, 0, 0);
      vecs[2] = mk(1, 4, 3, 1, 4, 7, 2);
      vecs[3] = mk(5, 2, 0, 5, 5, 0, 0);
      vecs[4] = mk(7, 4, 7, 7, 6, 5, 4);

      clear_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_add",   bus0.add_o,   0);
      check("rst_valid", bus0.valid_o, 0);
      check("rst_busy",  bus0.busy_o,  0);
      check("rst_done",  bus0.done_o,  0);
      check("rst_err",   bus0.err_o,   0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < int'(vecs[i].len); j++) exp_q.push_back(vecs[i].exp[j]);
         run_sb($sformatf("vec%0d", i), int'(vecs[i].base), int'(vecs[i].len), int'(vecs[i].stride));
      end

      // Maximum-length run wraps the 3-bit address space.
      for (int i = 0; i < 15; i++) exp_q.push_back(AW'(i));
      run_sb("maxlen", 0, 15, 1);

      // Gapped acceptance: address holds while adv_i is low.
      exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
      @(negedge clk);
      start0(0, 3, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus0.start = 1'b0;
         check($sformatf("gap_add%0d", k), bus0.add_o, gap_add[k]);
         check($sformatf("gap_done%0d", k), bus0.done_o, 0);
         bus0.adv_i = adv_pat[k][0];
         if (bus0.adv_i && bus0.valid_o && exp_q.size() != 0)
            check($sformatf("gap_sb%0d", k), bus0.add_o, exp_q.pop_front());
      end
      @(negedge clk);
      bus0.adv_i = 1'b0;
      check("gap_done_end", bus0.done_o, 1);
      check("gap_valid_end", bus0.valid_o, 0);
      check("gap_sb_empty", exp_q.size(), 0);
      exp_q.delete();

      // Abort in the cycle of the second accept.
      @(negedge clk);
      start0(0, 4, 1);
      bus0.adv_i = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      check("abort_first", bus0.add_o, 0);
      @(negedge clk);
      bus0.abort_i = 1'b1;
      @(negedge clk);
      bus0.abort_i = 1'b0;
      bus0.adv_i   = 1'b0;
      check("abort_valid", bus0.valid_o, 0);
      check("abort_busy",  bus0.busy_o,  0);
      check("abort_add",   bus0.add_o,   1);
      check("abort_done",  bus0.done_o,  0);

      // Zero-length start is rejected with a single err_o pulse.
      start0(5, 0, 1);
      @(negedge clk);
      bus0.start = 1'b0;
      check("err_pulse", bus0.err_o,  1);
      check("err_busy",  bus0.busy_o, 0);
      check("err_add",   bus0.add_o,  1);
      @(negedge clk);
      check("err_clear", bus0.err_o,  0);

      // Start together with abort has no effect.
      start0(4, 2, 1);
      bus0.abort_i = 1'b1;
      @(negedge clk);
      bus0.start   = 1'b0;
      bus0.abort_i = 1'b0;
      check("sa_busy", bus0.busy_o, 0);
      check("sa_err",  bus0.err_o,  0);
      check("sa_add",  bus0.add_o,  1);

      // Back-to-back runs with a one-cycle idle gap.
      start0(3, 1, 0);
      bus0.adv_i = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      check("b2b_add1",   bus0.add_o,   3);
      check("b2b_valid1", bus0.valid_o, 1);
      @(negedge clk);
      check("b2b_done1",  bus0.done_o,  1);
      check("b2b_idle",   bus0.valid_o, 0);
      start0(4, 1, 0);
      @(negedge clk);
      bus0.start = 1'b0;
      check("b2b_add2",   bus0.add_o,   4);
      check("b2b_valid2", bus0.valid_o, 1);
      check("b2b_ndone",  bus0.done_o,  0);
      @(negedge clk);
      check("b2b_done2",  bus0.done_o,  1);
      bus0.adv_i = 1'b0;

      // Continuous mode repeats until abort.
      bus1.start = 1'b1; bus1.base_i = 3'd2; bus1.len_i = 4'd2; bus1.stride_i = 3'd3;
      bus1.adv_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         bus1.start = 1'b0;
         check($sformatf("cont_add%0d", k),  bus1.add_o,  cexp[k]);
         check($sformatf("cont_done%0d", k), bus1.done_o, cdone[k]);
         check($sformatf("cont_busy%0d", k), bus1.busy_o, 1);
      end
      bus1.abort_i = 1'b1;
      @(negedge clk);
      bus1.abort_i = 1'b0;
      bus1.adv_i   = 1'b0;
      check("cont_abort_busy", bus1.busy_o, 0);
      check("cont_abort_done", bus1.done_o, 0);
      check("cont_abort_add",  bus1.add_o,  5);

      // Asynchronous reset between clock edges mid-run.
      start0(6, 3, 1);
      bus0.adv_i = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      check("ar_pre_add", bus0.add_o, 6);
      #2 rst = 1'b1;
      #1;
      check("ar_add",   bus0.add_o,   0);
      check("ar_valid", bus0.valid_o, 0);
      check("ar_busy",  bus0.busy_o,  0);
      @(negedge clk);
      rst = 1'b0;
      bus0.adv_i = 1'b0;
      exp_q.push_back(3'd6); exp_q.push_back(3'd7); exp_q.push_back(3'd0);
      run_sb("post_reset", 6, 3, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
